// File: rtl/maxpool_binarize_if.sv
// Stream and threshold-bank signals of the max-pool / binarise stage.
interface maxpool_binarize_if #(
  parameter int LANES = 7,
  parameter int DW    = 4,
  parameter int TW    = 11,
  parameter int CHW   = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [CHW-1:0]        in_ch;
  logic                  thr_we;
  logic [CHW-1:0]        thr_addr;
  logic [2*(TW+1)-1:0]   thr_wdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_max;
  logic                  out_bin;
  logic [CHW-1:0]        out_ch;

  modport slave (
    input  in_valid, in_data, in_ch, thr_we, thr_addr, thr_wdata, out_ready,
    output in_ready, out_valid, out_max, out_bin, out_ch
  );

  modport master (
    output in_valid, in_data, in_ch, thr_we, thr_addr, thr_wdata, out_ready,
    input  in_ready, out_valid, out_max, out_bin, out_ch
  );
endinterface

// File: rtl/maxpool_binarize.sv
// Lane-max and temporal-max pooling followed by per-channel threshold
// binarisation. Two register stages (window result, output) with a global
// stall driven by the output handshake.
module maxpool_binarize #(
  parameter int LANES = 7,
  parameter int DW    = 4,
  parameter int TW    = 11,
  parameter int CH    = 16,
  parameter int CHW   = 4,
  parameter int POOL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  maxpool_binarize_if.slave bus
);
  localparam int CNTW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int CHIW = (CH > 1) ? $clog2(CH) : 1;
  localparam int EW   = 2 * (TW + 1);
  // 2*max needs DW+1 bits; one extra bit keeps the compare sign-safe
  localparam int CW   = ((DW + 1 > TW) ? DW + 1 : TW) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(POOL - 1);

  logic                   adv1_s, in_ready_s, accept_s, last_s;
  logic signed [DW-1:0]   lane_max_s, lane_v_s;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0]   acc_q, acc_d;
  logic                   s1_valid_q;
  logic signed [DW-1:0]   s1_max_q;
  logic [CHW-1:0]         s1_ch_q;
  logic                   out_valid_q, out_bin_q;
  logic [DW-1:0]          out_max_q;
  logic [CHW-1:0]         out_ch_q;
  logic [EW-1:0]          bank_q [CH];
  logic [CHIW-1:0]        rd_idx_s;
  logic [EW-1:0]          entry_s;
  logic                   sign_s, gt_s, bin_s, wr_ok_s;
  logic signed [TW-1:0]   thr_s;
  logic signed [CW-1:0]   dbl_s, thr_ext_s;

  assign adv1_s      = !out_valid_q || bus.out_ready;
  assign in_ready_s  = !s1_valid_q || adv1_s;
  assign accept_s    = bus.in_valid && in_ready_s;
  assign last_s      = (cnt_q == CNT_LAST);
  assign wr_ok_s     = (32'(bus.thr_addr) < 32'(CH));
  assign bus.in_ready = in_ready_s;

  // Signed maximum across all lanes of the incoming beat (lane 0 in MSBs)
  always_comb begin
    lane_max_s = $signed(bus.in_data[LANES*DW-1 -: DW]);
    lane_v_s   = lane_max_s;
    for (int i = 1; i < LANES; i++) begin
      lane_v_s = $signed(bus.in_data[(LANES-1-i)*DW +: DW]);
      if (lane_v_s > lane_max_s) lane_max_s = lane_v_s;
      else                       lane_max_s = lane_max_s;
    end
  end

  // Window accumulation: restart on the first beat, else keep the running max
  always_comb begin
    if (cnt_q == {CNTW{1'b0}})   acc_d = lane_max_s;
    else if (lane_max_s > acc_q) acc_d = lane_max_s;
    else                         acc_d = acc_q;
    if (last_s) cnt_d = {CNTW{1'b0}};
    else        cnt_d = cnt_q + CNTW'(1);
  end

  // Window counter and running max move only on accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNTW{1'b0}};
      acc_q <= {DW{1'b0}};
    end else if (accept_s) begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Stage 1 holds one completed window until stage 2 can take it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_max_q   <= {DW{1'b0}};
      s1_ch_q    <= {CHW{1'b0}};
    end else if (accept_s && last_s) begin
      s1_valid_q <= 1'b1;
      s1_max_q   <= acc_d;
      s1_ch_q    <= bus.in_ch;
    end else if (adv1_s) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Threshold lookup and signed compare of twice the pooled max
  always_comb begin
    if (32'(s1_ch_q) < 32'(CH)) rd_idx_s = CHIW'(s1_ch_q);
    else                        rd_idx_s = {CHIW{1'b0}};
    entry_s = bank_q[rd_idx_s];
    if (!s1_max_q[DW-1]) begin
      sign_s = entry_s[EW-1];
      thr_s  = $signed(entry_s[EW-2 -: TW]);
    end else begin
      sign_s = entry_s[TW];
      thr_s  = $signed(entry_s[TW-1:0]);
    end
    dbl_s     = {{(CW-DW-1){s1_max_q[DW-1]}}, s1_max_q, 1'b0};
    thr_ext_s = {{(CW-TW){thr_s[TW-1]}}, thr_s};
    gt_s      = (dbl_s > thr_ext_s);
    bin_s     = (gt_s == sign_s);
  end

  // Output register: loads on advance, holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_max_q   <= {DW{1'b0}};
      out_bin_q   <= 1'b0;
      out_ch_q    <= {CHW{1'b0}};
    end else if (adv1_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_max_q <= s1_max_q;
        out_bin_q <= bin_s;
        out_ch_q  <= s1_ch_q;
      end
    end
  end

  // Threshold bank: reset clears every entry, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) bank_q[i] <= {EW{1'b0}};
    end else if (bus.thr_we && wr_ok_s) begin
      bank_q[CHIW'(bus.thr_addr)] <= bus.thr_wdata;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_maxpool_binarize.sv
// Scoreboard bench: one POOL=1 and one POOL=4 instance with a reference model.
module tb_maxpool_binarize;
  typedef struct {
    int mx;
    int bin;
    int ch;
  } exp_t;

  logic clk;
  logic rst;
  logic bp_en;
  int   n_cmp;
  int   n_err;
  exp_t q1[$];
  exp_t q4[$];
  int   m_cnt [2];
  int   m_acc [2];
  logic [23:0] m_bank [2][16];

  maxpool_binarize_if #(.LANES(7), .DW(4), .TW(11), .CHW(4)) if1 ();
  maxpool_binarize_if #(.LANES(7), .DW(4), .TW(11), .CHW(4)) if4 ();

  maxpool_binarize #(.LANES(7), .DW(4), .TW(11), .CH(16), .CHW(4), .POOL(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  maxpool_binarize #(.LANES(7), .DW(4), .TW(11), .CH(16), .CHW(4), .POOL(4))
    u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lanemax(input logic [27:0] d);
    int m;
    int v;
    logic signed [3:0] f;
    m = -100;
    for (int i = 0; i < 7; i++) begin
      f = d[(6-i)*4 +: 4];
      v = f;
      if (v > m) m = v;
    end
    return m;
  endfunction

  function automatic int model_bin(input int mx, input logic [23:0] e);
    logic signed [10:0] t;
    logic s;
    int ti;
    if (mx >= 0) begin s = e[23]; t = e[22:12]; end
    else         begin s = e[11]; t = e[10:0];  end
    ti = t;
    return ((2 * mx > ti) == s) ? 1 : 0;
  endfunction

  function automatic logic [23:0] thr_word(input int ps, input int pt, input int ns, input int nt);
    return {ps[0], pt[10:0], ns[0], nt[10:0]};
  endfunction

  function automatic logic [27:0] lanes7(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6);
    return {l0[3:0], l1[3:0], l2[3:0], l3[3:0], l4[3:0], l5[3:0], l6[3:0]};
  endfunction

  // all lanes -8 except lane pos, which carries v
  function automatic logic [27:0] lanes_one(input int v, input int pos);
    logic [27:0] d;
    int lv;
    for (int i = 0; i < 7; i++) begin
      lv = (i == pos) ? v : -8;
      d[(6-i)*4 +: 4] = lv[3:0];
    end
    return d;
  endfunction

  function automatic int qsize(input int u);
    return (u == 1) ? q1.size() : q4.size();
  endfunction

  task automatic send_beat(input int u, input logic [27:0] d, input int ch);
    int w;
    int k;
    int pool;
    int lm;
    exp_t e;
    k = (u == 1) ? 0 : 1;
    pool = (u == 1) ? 1 : 4;
    if (u == 1) begin if1.in_valid = 1'b1; if1.in_data = d; if1.in_ch = ch[3:0]; end
    else        begin if4.in_valid = 1'b1; if4.in_data = d; if4.in_ch = ch[3:0]; end
    w = 0;
    forever begin
      @(negedge clk);
      if (((u == 1) ? if1.in_ready : if4.in_ready) == 1'b1) break;
      w++;
      if (w > 200) begin
        chk_val("in_ready_wait", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (u == 1) if1.in_valid = 1'b0;
    else        if4.in_valid = 1'b0;
    lm = lanemax(d);
    if (m_cnt[k] == 0) m_acc[k] = lm;
    else if (lm > m_acc[k]) m_acc[k] = lm;
    if (m_cnt[k] == pool - 1) begin
      e.mx  = m_acc[k];
      e.ch  = ch;
      e.bin = model_bin(m_acc[k], m_bank[k][ch]);
      if (u == 1) q1.push_back(e);
      else        q4.push_back(e);
      m_cnt[k] = 0;
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic wr_thr(input int u, input int addr, input logic [23:0] w);
    int k;
    k = (u == 1) ? 0 : 1;
    if (u == 1) begin if1.thr_we = 1'b1; if1.thr_addr = addr[3:0]; if1.thr_wdata = w; end
    else        begin if4.thr_we = 1'b1; if4.thr_addr = addr[3:0]; if4.thr_wdata = w; end
    @(posedge clk);
    #1;
    if (u == 1) if1.thr_we = 1'b0;
    else        if4.thr_we = 1'b0;
    m_bank[k][addr] = w;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int u);
    int w;
    w = 0;
    while (qsize(u) != 0 && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk_val("drain", qsize(u), 0);
    idle(3);
  endtask

  task automatic clear_model();
    q1.delete();
    q4.delete();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_acc[k] = 0;
      for (int a = 0; a < 16; a++) m_bank[k][a] = 24'h0;
    end
  endtask

  // Scoreboard for the POOL=1 instance: every valid cycle must show the queue head
  always @(negedge clk) begin
    if (!rst && if1.out_valid) begin
      if (q1.size() == 0) chk_val("u1_unexpected", 1, 0);
      else begin
        chk_val("u1_max", $signed(if1.out_max), q1[0].mx);
        chk_val("u1_bin", int'(if1.out_bin), q1[0].bin);
        chk_val("u1_ch", int'(if1.out_ch), q1[0].ch);
        if (if1.out_ready) void'(q1.pop_front());
      end
    end
  end

  // Scoreboard for the POOL=4 instance
  always @(negedge clk) begin
    if (!rst && if4.out_valid) begin
      if (q4.size() == 0) chk_val("u4_unexpected", 1, 0);
      else begin
        chk_val("u4_max", $signed(if4.out_max), q4[0].mx);
        chk_val("u4_bin", int'(if4.out_bin), q4[0].bin);
        chk_val("u4_ch", int'(if4.out_ch), q4[0].ch);
        if (if4.out_ready) void'(q4.pop_front());
      end
    end
  end

  // Pseudo-random consumer stalls on the POOL=1 instance
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      if1.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    bp_en = 1'b0;
    rst   = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = 28'h0; if1.in_ch = 4'h0;
    if1.thr_we = 1'b0; if1.thr_addr = 4'h0; if1.thr_wdata = 24'h0; if1.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = 28'h0; if4.in_ch = 4'h0;
    if4.thr_we = 1'b0; if4.thr_addr = 4'h0; if4.thr_wdata = 24'h0; if4.out_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_val("rst_out_valid", int'(if1.out_valid), 0);
    chk_val("rst_out_max", int'(if1.out_max), 0);
    chk_val("rst_out_bin", int'(if1.out_bin), 0);
    chk_val("rst_out_ch", int'(if1.out_ch), 0);
    chk_val("rst_in_ready", int'(if1.in_ready), 1);
    chk_val("rst_in_ready4", int'(if4.in_ready), 1);
    chk_val("rst_out_valid4", int'(if4.out_valid), 0);
    @(posedge clk);
    #1;

    // Unwritten bank, all lanes -1, plus two-cycle latency
    send_beat(1, lanes7(-1, -1, -1, -1, -1, -1, -1), 5);
    @(negedge clk);
    chk_val("lat_edge_k", int'(if1.out_valid), 0);
    @(negedge clk);
    chk_val("lat_edge_k1", int'(if1.out_valid), 1);
    drain(1);

    // Positive branch on channel 3
    wr_thr(1, 3, thr_word(1, 10, 0, -4));
    send_beat(1, lanes7(3, -2, 1, 0, -8, 7, -1), 3);
    drain(1);
    wr_thr(1, 3, thr_word(1, 14, 0, -4));
    send_beat(1, lanes7(3, -2, 1, 0, -8, 7, -1), 3);
    drain(1);

    // Negative branch on channel 3
    send_beat(1, lanes7(-3, -3, -3, -3, -3, -3, -3), 3);
    drain(1);
    wr_thr(1, 3, thr_word(1, 14, 1, -4));
    send_beat(1, lanes7(-3, -3, -3, -3, -3, -3, -3), 3);
    drain(1);

    // Temporal pool of four beats with gaps between them
    send_beat(4, lanes_one(2, 0), 1);
    idle(2);
    send_beat(4, lanes_one(5, 3), 2);
    idle(1);
    send_beat(4, lanes_one(-1, 6), 3);
    idle(3);
    send_beat(4, lanes_one(3, 2), 9);
    drain(4);

    // Ten back-to-back windows under random consumer stalls
    bp_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      send_beat(1, 28'($urandom), $urandom_range(0, 15));
    end
    drain(1);
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    if1.out_ready = 1'b1;
    idle(2);

    // Write colliding with the stage-2 evaluation of the same entry
    send_beat(1, lanes_one(7, 1), 3);
    wr_thr(1, 3, thr_word(1, 0, 1, -4));
    drain(1);
    send_beat(1, lanes_one(7, 1), 3);
    drain(1);

    // Reset mid-window discards partial accumulation
    send_beat(4, lanes_one(7, 0), 0);
    send_beat(4, lanes_one(6, 0), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk_val("rst_mid_no_out", int'(if4.out_valid), 0);
    @(posedge clk);
    #1;
    send_beat(4, lanes_one(1, 4), 2);
    send_beat(4, lanes_one(-2, 4), 4);
    send_beat(4, lanes_one(0, 4), 6);
    send_beat(4, lanes_one(-5, 4), 11);
    drain(4);

    chk_val("final_q1_empty", q1.size(), 0);
    chk_val("final_q4_empty", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
